// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter driving the async FIFO write port
module fifo_wr_arbiter #(
  parameter int data_width = 8,
  parameter int NUM_REQ    = 4,
  parameter int MAX_BURST  = 4,
  localparam int IDW = $clog2(NUM_REQ),
  localparam int BCW = $clog2(MAX_BURST + 1)
) (
  input  logic                          wr_clk,
  input  logic                          wr_rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*data_width-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          full,
  output logic                          wr_en,
  output logic [data_width-1:0]         data_in,
  output logic                          grant_valid,
  output logic [IDW-1:0]                grant_id,
  output logic [15:0]                   word_count
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t         state;
  logic [IDW-1:0] rr_ptr;
  logic [BCW-1:0] burst_cnt;

  logic           pick_found;
  logic [IDW-1:0] pick_id;
  int             idx;
  logic           owner_valid;
  logic           xfer;
  logic           release_now;
  logic [IDW-1:0] next_ptr;

  // Scan from the far end so the last hit written is the one nearest rr_ptr.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    idx        = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = (int'(rr_ptr) + i) % NUM_REQ;
      if (req_valid[idx]) begin
        pick_found = 1'b1;
        pick_id    = idx[IDW-1:0];
      end
    end
  end

  always_comb begin
    owner_valid = req_valid[grant_id];
    xfer        = grant_valid & owner_valid & ~full;
    wr_en       = xfer;
    data_in     = '0;
    req_ready   = '0;
    if (grant_valid) begin
      data_in = req_data[grant_id*data_width +: data_width];
      if (!full)
        req_ready[grant_id] = 1'b1;
    end
    release_now = grant_valid &
                  (~owner_valid | (xfer & (burst_cnt == BCW'(MAX_BURST - 1))));
    next_ptr    = (int'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + 1'b1;
  end

  always_ff @(posedge wr_clk or negedge wr_rst) begin
    if (!wr_rst) begin
      state       <= IDLE;
      grant_valid <= 1'b0;
      grant_id    <= '0;
      rr_ptr      <= '0;
      burst_cnt   <= '0;
      word_count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            grant_id    <= pick_id;
            burst_cnt   <= '0;
            state       <= GRANT;
            grant_valid <= 1'b1;
          end
        end
        GRANT: begin
          if (xfer) begin
            burst_cnt  <= burst_cnt + 1'b1;
            word_count <= word_count + 16'd1;
          end
          if (release_now) begin
            state       <= IDLE;
            grant_valid <= 1'b0;
            rr_ptr      <= next_ptr;
          end
        end
        default: begin
          state       <= IDLE;
          grant_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin arbiter that shares the single write port of the asynchronous FIFO among `NUM_REQ` producers in the write-clock domain. Each producer offers words over a valid/ready handshake. The arbiter grants one producer at a time for a burst of up to `MAX_BURST` words and drives the FIFO's `wr_en`/`data_in` directly. It never writes while `full` is high. It sits between the producer blocks and the FIFO write side.

## Interface
- `data_width`, default 8: FIFO word width.
- `NUM_REQ`, default 4: number of requesters, ≥2.
- `MAX_BURST`, default 4: maximum words per grant, ≥1.
- `IDW` (localparam) = `$clog2(NUM_REQ)`; `BCW` (localparam) = `$clog2(MAX_BURST+1)`.

- `wr_clk`  in  1  FIFO write clock; sole clock of the block.
- `wr_rst`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  NUM_REQ  bit i: requester i offers a word.
- `req_data`  in  NUM_REQ*data_width  word of requester i in bits [i*data_width +: data_width].
- `req_ready`  out  NUM_REQ  bit i: word of requester i accepted this cycle if `req_valid[i]` is also high.
- `full`  in  1  FIFO full flag (write domain).
- `wr_en`  out  1  FIFO write enable.
- `data_in`  out  data_width  FIFO write data.
- `grant_valid`  out  1  a requester currently owns the port.
- `grant_id`  out  IDW  index of the owner.
- `word_count`  out  16  total words written since reset; wraps at 0xFFFF→0.

## Operation
- FSM has two states: IDLE and GRANT. Registers: `state`, `grant_id`, `rr_ptr` (IDW), `burst_cnt` (BCW), `word_count`.
- IDLE:
  - If any `req_valid` is high, select the first set bit scanning `rr_ptr`, `rr_ptr+1`, … mod NUM_REQ.
  - Register the winner into `grant_id`, clear `burst_cnt`, and go to GRANT.
  - No transfer happens in IDLE.
- GRANT, owner o:
  - `xfer = req_valid[o] & ~full`.
  - `req_ready[o] = ~full`; every other `req_ready` bit is 0.
  - `wr_en = xfer`; `data_in = req_data` slice o.
  - On `xfer`, `burst_cnt` and `word_count` each increment by 1.
- Release from GRANT, leaving for IDLE at the next edge with `rr_ptr ← (o+1) mod NUM_REQ`, happens when either:
  - `xfer` occurs and `burst_cnt == MAX_BURST-1`, or
  - `req_valid[o] == 0` in that cycle, whatever the state of `full`. No transfer occurs in this case.
- While `full` is high and `req_valid[o]` is high: hold the grant, no transfer, `burst_cnt` frozen. There is no timeout.
- `data_in` = 0 whenever `grant_valid` = 0.
- `wr_en`, `req_ready`, and `data_in` are combinational from registered state plus `full`/`req_valid`/`req_data`. There is no register between the arbiter and the FIFO, so `full` is honoured in the same cycle.
- Requesters must hold `req_valid` and `req_data` stable until accepted. A requester that drops valid while it is the owner loses the grant.

## Timing
- Reset (async assert, sync deassert by the upstream reset synchronizer) sets:
  - `state`=IDLE, `rr_ptr`=0, `grant_id`=0, `burst_cnt`=0, `word_count`=0.
  - Outputs `wr_en`=0, `req_ready`=0, `data_in`=0, `grant_valid`=0, `grant_id`=0, `word_count`=0.
- Reset asserted mid-burst: all outputs go to reset values immediately, not at the next edge. The in-flight word is not written.
- Arbitration latency: `req_valid` seen in IDLE at edge k gives `grant_valid`=1 after edge k. The first write can happen in the cycle ending at edge k+1.
- Throughput:
  - Up to MAX_BURST back-to-back writes per grant.
  - One IDLE bubble cycle between grants, including re-grant to the same requester.
  - Peak rate is MAX_BURST/(MAX_BURST+1) words per cycle.
- `rr_ptr` wraps from NUM_REQ-1 to 0.
- With a single active requester, it is re-granted after each bubble.
- `full` rising in a cycle blocks that cycle's write. `full` falling allows a write in the same cycle.

## Test plan
- **Reset:** hold `wr_rst`=0 with all `req_valid`=1 → `wr_en`=0, `req_ready`=0, `data_in`=0, `grant_valid`=0, `word_count`=0.
- **Single requester:** `req_valid`=0001 continuously, data 0x10,0x11,… advancing on `req_ready`, `full`=0, MAX_BURST=4 →
  - cycle pattern: grant, writes 0x10–0x13 on 4 consecutive cycles, 1 bubble, writes 0x14–0x17;
  - `word_count`=8.
- **Round-robin:** all four requesters valid, each with a unique data tag → `grant_id` sequence 0,1,2,3,0, 4 words each, bubble between each. FIFO receives 16 words in that order.
- **Full stall:** `full`=1 for 3 cycles after the 2nd word of a burst → `wr_en`=0 and `req_ready`=0 for those 3 cycles, grant held. The remaining 2 words follow; the burst total is exactly 4.
- **Early release:** owner 1 drops `req_valid` after 2 words while requester 2 is valid → release, one IDLE cycle, `grant_id`=2. Requester 1 has exactly 2 words written.
- **Mid-burst reset:** assert `wr_rst`=0 asynchronously between clock edges during word 3 of a burst → `wr_en` falls before the next edge and all state clears. After release, arbitration restarts from requester 0.
